// File: rtl/spike_event_scheduler_if.sv
// Handshake bundle between the spike source, the scheduler and the weight-fetch side.
// The slave modport is the scheduler's view.
interface spike_event_scheduler_if #(
    parameter int NUM_IN = 961,
    parameter int IDX_W  = 10
);
    logic [NUM_IN-1:0] frame_in;
    logic              frame_valid;
    logic              frame_ready;
    logic [IDX_W-1:0]  evt_idx;
    logic              evt_valid;
    logic              evt_ready;
    logic              frame_done;
    logic [IDX_W-1:0]  evt_count;
    logic              flush;
    logic              busy;

    modport master (
        output frame_in, frame_valid, evt_ready, flush,
        input  frame_ready, evt_idx, evt_valid, frame_done, evt_count, busy
    );

    modport slave (
        input  frame_in, frame_valid, evt_ready, flush,
        output frame_ready, evt_idx, evt_valid, frame_done, evt_count, busy
    );
endinterface

// File: rtl/spike_event_scheduler.sv
// Serialises one spike frame into ascending active-spike indices, scanning SCAN_W bits per
// cycle, then pulses frame_done with the number of events emitted.
//
//   state | meaning
//   IDLE  | waiting for a frame, frame_ready=1
//   SCAN  | presenting the lowest set bit of the current chunk, one chunk at a time
//   DONE  | one-cycle frame_done pulse carrying evt_count
module spike_event_scheduler #(
    parameter int NUM_IN = 961,
    parameter int IDX_W  = 10,
    parameter int SCAN_W = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    spike_event_scheduler_if.slave    io_sched
);
    localparam int NUM_CHUNK = (NUM_IN + SCAN_W - 1) / SCAN_W;
    localparam int PAD_W     = NUM_CHUNK * SCAN_W;
    localparam int PTR_W     = (NUM_CHUNK > 1) ? $clog2(NUM_CHUNK) : 1;
    localparam int POS_W     = (SCAN_W > 1) ? $clog2(SCAN_W) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_CHUNK - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [SCAN_W-1:0]  r_work [NUM_CHUNK];
    logic [PTR_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_count;
    logic [IDX_W-1:0]   r_evt_count;

    logic [PAD_W-1:0]   w_frame_pad;
    logic [SCAN_W-1:0]  w_chunk;
    logic [SCAN_W-1:0]  w_onehot;
    logic [SCAN_W-1:0]  w_chunk_clr;
    logic [POS_W-1:0]   w_pos;
    logic [IDX_W-1:0]   w_idx;
    logic               w_evt_valid;
    logic               w_fire;
    logic               w_advance;

    assign w_frame_pad = PAD_W'(io_sched.frame_in);
    assign w_chunk     = r_work[r_ptr];
    // Isolate the lowest set bit so a transfer clears exactly that spike.
    assign w_onehot    = w_chunk & (~w_chunk + SCAN_W'(1));
    assign w_chunk_clr = w_chunk & ~w_onehot;
    assign w_evt_valid = (r_state == SCAN) && (w_chunk != '0);
    assign w_fire      = w_evt_valid && io_sched.evt_ready && !io_sched.flush;
    assign w_advance   = (r_state == SCAN) &&
                         ((w_chunk == '0) || (w_fire && (w_chunk_clr == '0)));
    assign w_idx       = IDX_W'(IDX_W'(r_ptr) * IDX_W'(SCAN_W) + IDX_W'(w_pos));

    always_comb begin
        w_pos = '0;
        for (int b = SCAN_W - 1; b >= 0; b--) begin
            if (w_chunk[b]) w_pos = POS_W'(b);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (io_sched.flush) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (io_sched.frame_valid) w_state_next = SCAN;
                SCAN:    if (w_advance && (r_ptr == LAST_PTR)) w_state_next = DONE;
                DONE:    w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || io_sched.flush) begin
            for (int c = 0; c < NUM_CHUNK; c++) r_work[c] <= '0;
            r_ptr   <= '0;
            r_count <= '0;
            if (i_rst) r_evt_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_sched.frame_valid) begin
                        for (int c = 0; c < NUM_CHUNK; c++)
                            r_work[c] <= w_frame_pad[c*SCAN_W +: SCAN_W];
                        r_ptr   <= '0;
                        r_count <= '0;
                    end
                end
                SCAN: begin
                    if (w_fire) begin
                        r_work[r_ptr] <= w_chunk_clr;
                        r_count       <= r_count + IDX_W'(1);
                    end
                    // Pointer wraps to 0 so it never addresses past the last chunk.
                    if (w_advance) r_ptr <= (r_ptr == LAST_PTR) ? '0 : r_ptr + PTR_W'(1);
                end
                DONE:    r_evt_count <= r_count;
                default: ;
            endcase
        end
    end

    always_comb begin
        io_sched.frame_ready = (r_state == IDLE);
        io_sched.busy        = (r_state != IDLE);
        io_sched.frame_done  = (r_state == DONE);
        io_sched.evt_valid   = w_evt_valid;
        io_sched.evt_idx     = w_evt_valid ? w_idx : '0;
        io_sched.evt_count   = (r_state == DONE) ? r_count : r_evt_count;
    end
endmodule

// File: tb/tb_spike_event_scheduler.sv
// Scoreboard bench: the driver pushes the model's expected events per frame,
// a negedge monitor pops and compares every handshake and frame_done.
module tb_spike_event_scheduler;
    localparam int NUM_IN = 961;
    localparam int IDX_W  = 10;
    localparam int SCAN_W = 32;
    localparam int NCH    = (NUM_IN + SCAN_W - 1) / SCAN_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spike_event_scheduler_if #(.NUM_IN(NUM_IN), .IDX_W(IDX_W)) sif ();

    spike_event_scheduler #(.NUM_IN(NUM_IN), .IDX_W(IDX_W), .SCAN_W(SCAN_W)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .io_sched (sif)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_idx_q[$];
    int exp_cnt_q[$];
    int exp_lat_q[$];
    int done_cnt = 0;
    int last_accept = 0;
    int ready_mode = 0;
    bit post_done = 0;
    bit hold_pend = 0;
    logic [IDX_W-1:0] hold_idx = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected indices, count and ready-always-high scan length.
    task automatic expect_frame(input logic [NUM_IN-1:0] v, input bit lat_known);
        int n;
        int lat;
        int pop;
        int i;
        n = 0;
        lat = 0;
        for (int c = 0; c < NCH; c++) begin
            pop = 0;
            for (int b = 0; b < SCAN_W; b++) begin
                i = c * SCAN_W + b;
                if (i < NUM_IN && v[i]) begin
                    exp_idx_q.push_back(i);
                    pop++;
                end
            end
            lat += (pop == 0) ? 1 : pop;
            n += pop;
        end
        exp_cnt_q.push_back(n);
        exp_lat_q.push_back(lat_known ? lat : -1);
    endtask

    always @(negedge clk) begin
        if (!rst && !sif.flush) begin
            if (post_done) chk("ready_after_done", {31'd0, sif.frame_ready}, 32'd1);
            if (hold_pend) begin
                chk("hold_valid", {31'd0, sif.evt_valid}, 32'd1);
                chk("hold_idx", 32'(sif.evt_idx), 32'(hold_idx));
            end
            if (sif.frame_valid && sif.frame_ready) last_accept = cyc + 1;
            if (sif.evt_valid && sif.evt_ready) begin
                if (exp_idx_q.size() == 0) chk("evt_unexpected", 32'(sif.evt_idx), 32'hFFFF_FFFF);
                else chk("evt_idx", 32'(sif.evt_idx), 32'(exp_idx_q.pop_front()));
            end
            if (sif.frame_done) begin
                done_cnt++;
                if (exp_cnt_q.size() == 0) begin
                    chk("done_unexpected", 32'(sif.evt_count), 32'hFFFF_FFFF);
                end else begin
                    int lat;
                    chk("evt_count", 32'(sif.evt_count), 32'(exp_cnt_q.pop_front()));
                    lat = exp_lat_q.pop_front();
                    if (lat >= 0) chk("done_latency", 32'(cyc - last_accept), 32'(lat));
                end
            end
            post_done = sif.frame_done;
            hold_pend = sif.evt_valid && !sif.evt_ready;
            hold_idx  = sif.evt_idx;
        end else begin
            post_done = 0;
            hold_pend = 0;
        end
    end

    initial begin
        int k;
        k = 0;
        sif.evt_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       sif.evt_ready = 1'b1;
                1:       sif.evt_ready = 1'($urandom_range(1));
                default: sif.evt_ready = ((k % 4) == 0) || ((k % 4) == 3);
            endcase
            k++;
        end
    end

    task automatic send_frame(input logic [NUM_IN-1:0] v, input bit lat_known);
        bit seen;
        expect_frame(v, lat_known);
        seen = 0;
        for (int t = 0; t < 5000 && !seen; t++) begin
            @(negedge clk);
            seen = sif.frame_ready;
        end
        if (!seen) chk("frame_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        sif.frame_in    = v;
        sif.frame_valid = 1'b1;
        @(posedge clk);
        #1;
        sif.frame_valid = 1'b0;
    endtask

    task automatic wait_done();
        int start;
        bit got;
        start = done_cnt;
        got = 0;
        for (int t = 0; t < 5000 && !got; t++) begin
            @(negedge clk);
            got = (done_cnt != start);
        end
        if (!got) chk("frame_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_idle(input bit with_count);
        chk("idle_frame_ready", {31'd0, sif.frame_ready}, 32'd1);
        chk("idle_evt_valid", {31'd0, sif.evt_valid}, 32'd0);
        chk("idle_evt_idx", 32'(sif.evt_idx), 32'd0);
        chk("idle_frame_done", {31'd0, sif.frame_done}, 32'd0);
        chk("idle_busy", {31'd0, sif.busy}, 32'd0);
        if (with_count) chk("idle_evt_count", 32'(sif.evt_count), 32'd0);
    endtask

    task automatic abort_test(input bit use_rst);
        logic [NUM_IN-1:0] v;
        bit found;
        int snap;
        v = '0;
        v[10] = 1'b1;
        v[20] = 1'b1;
        v[300] = 1'b1;
        ready_mode = 0;
        send_frame(v, 1);
        found = 0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge clk);
            found = sif.evt_valid && sif.evt_ready && (sif.evt_idx == 10'd20);
        end
        chk("saw_idx20", {31'd0, found}, 32'd1);
        @(posedge clk);
        #1;
        if (use_rst) rst = 1'b1;
        else         sif.flush = 1'b1;
        exp_idx_q.delete();
        exp_cnt_q.delete();
        exp_lat_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        sif.flush = 1'b0;
        @(negedge clk);
        check_idle(use_rst);
        snap = done_cnt;
        repeat (40) @(negedge clk);
        chk("no_done_after_abort", 32'(done_cnt), 32'(snap));
        v = '0;
        v[7] = 1'b1;
        send_frame(v, 1);
        wait_done();
    endtask

    initial begin
        logic [NUM_IN-1:0] v;
        int dens;
        sif.flush = 1'b0;
        sif.frame_valid = 1'b0;
        sif.frame_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle(1);

        ready_mode = 0;
        v = '0; v[0] = 1'b1;
        send_frame(v, 1); wait_done();
        v = '0; v[NUM_IN-1] = 1'b1;
        send_frame(v, 1); wait_done();
        v = '1;
        send_frame(v, 1); wait_done();
        v = '0;
        send_frame(v, 1); wait_done();

        ready_mode = 2;
        v = '0; v[5] = 1'b1; v[37] = 1'b1; v[38] = 1'b1; v[900] = 1'b1;
        send_frame(v, 0); wait_done();

        abort_test(1);
        abort_test(0);

        ready_mode = 1;
        for (int f = 0; f < 8; f++) begin
            case (f % 4)
                0:       dens = 3;
                1:       dens = 50;
                2:       dens = 95;
                default: dens = 0;
            endcase
            for (int i = 0; i < NUM_IN; i++) v[i] = ($urandom_range(99) < dens);
            send_frame(v, 0);
            if (f == 0) begin
                // A frame offered while busy must be dropped, not queued.
                @(negedge clk);
                chk("busy_in_frame", {31'd0, sif.busy}, 32'd1);
                chk("not_ready_in_frame", {31'd0, sif.frame_ready}, 32'd0);
                @(posedge clk);
                #1;
                for (int i = 0; i < NUM_IN; i++) sif.frame_in[i] = 1'($urandom_range(1));
                sif.frame_valid = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                sif.frame_valid = 1'b0;
            end
            wait_done();
        end

        repeat (5) @(negedge clk);
        chk("idx_queue_drained", 32'(exp_idx_q.size()), 32'd0);
        chk("cnt_queue_drained", 32'(exp_cnt_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
